// File: rtl/block_sequencer_if.sv
// rtl/block_sequencer_if.sv - handshake bundle between the block sequencer and its neighbours
interface block_sequencer_if #(
    parameter int COORD_W = 8
);
    logic               frame_start;
    logic [COORD_W-1:0] blocks_x;
    logic [COORD_W-1:0] blocks_y;
    logic               fetch_req;
    logic [COORD_W-1:0] fetch_row;
    logic [COORD_W-1:0] fetch_col;
    logic               fetch_ack;
    logic               start_block;
    logic               block_done;
    logic               out_valid;
    logic               out_ready;
    logic [COORD_W-1:0] out_row;
    logic [COORD_W-1:0] out_col;
    logic               out_last;
    logic               busy;
    logic               frame_done;
    logic               err;

    // Sequencer side
    modport master (
        input  frame_start, blocks_x, blocks_y, fetch_ack, block_done, out_ready,
        output fetch_req, fetch_row, fetch_col, start_block, out_valid,
               out_row, out_col, out_last, busy, frame_done, err
    );

    // Fetcher / datapath / entropy-coder side
    modport slave (
        output frame_start, blocks_x, blocks_y, fetch_ack, block_done, out_ready,
        input  fetch_req, fetch_row, fetch_col, start_block, out_valid,
               out_row, out_col, out_last, busy, frame_done, err
    );
endinterface

// File: rtl/block_sequencer.sv
// rtl/block_sequencer.sv - raster-order frame controller driving compress_block per 8x8 block
module block_sequencer #(
    parameter int COORD_W        = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TMO_W          = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    block_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_START   = 3'd2,
        S_COMPUTE = 3'd3,
        S_OUTPUT  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);

    state_t             state_q, state_d;
    logic [COORD_W-1:0] row_q, row_d;
    logic [COORD_W-1:0] col_q, col_d;
    logic [COORD_W-1:0] bx_q, bx_d;
    logic [COORD_W-1:0] by_q, by_d;
    logic [TMO_W-1:0]   wdog_q, wdog_d;
    logic               err_q, err_d;
    logic               zdone_q, zdone_d;

    logic               col_at_end;
    logic               is_last;

    assign col_at_end = (col_q == bx_q - ONE);
    assign is_last    = col_at_end && (row_q == by_q - ONE);

    // State and datapath registers; reset aborts any frame and clears the error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            bx_q    <= '0;
            by_q    <= '0;
            wdog_q  <= '0;
            err_q   <= 1'b0;
            zdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            wdog_q  <= wdog_d;
            err_q   <= err_d;
            zdone_q <= zdone_d;
        end
    end

    // Next-state logic: one block per FETCH/START/COMPUTE/OUTPUT loop
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        bx_d    = bx_q;
        by_d    = by_q;
        wdog_d  = wdog_q;
        err_d   = err_q;
        zdone_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.frame_start) begin
                    if ((bus.blocks_x != '0) && (bus.blocks_y != '0)) begin
                        bx_d    = bus.blocks_x;
                        by_d    = bus.blocks_y;
                        row_d   = '0;
                        col_d   = '0;
                        err_d   = 1'b0;
                        state_d = S_FETCH;
                    end else begin
                        // Empty frame: report completion without touching err
                        zdone_d = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                if (bus.fetch_ack) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                wdog_d  = '0;
                state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                // block_done takes priority over a coincident timeout
                if (bus.block_done) begin
                    state_d = S_OUTPUT;
                end else if (wdog_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wdog_d = wdog_q + TMO_W'(1);
                end
            end
            S_OUTPUT: begin
                if (bus.out_ready) begin
                    if (is_last) begin
                        state_d = S_DONE;
                    end else begin
                        if (col_at_end) begin
                            col_d = '0;
                            row_d = row_q + ONE;
                        end else begin
                            col_d = col_q + ONE;
                        end
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode from registers only
    assign bus.fetch_req   = (state_q == S_FETCH);
    assign bus.fetch_row   = row_q;
    assign bus.fetch_col   = col_q;
    assign bus.start_block = (state_q == S_START);
    assign bus.out_valid   = (state_q == S_OUTPUT);
    assign bus.out_row     = row_q;
    assign bus.out_col     = col_q;
    assign bus.out_last    = (state_q == S_OUTPUT) && is_last;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.frame_done  = (state_q == S_DONE) || zdone_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_block_sequencer.sv
// tb/tb_block_sequencer.sv - directed self-checking bench for block_sequencer
module tb_block_sequencer;

    logic clk;
    logic rst_n;
    logic done_en;
    int   n_tests;
    int   n_fail;

    int         n_start;
    int         n_fetch;
    int         n_fdone;
    int         n_hs;
    logic [7:0] hs_row  [64];
    logic [7:0] hs_col  [64];
    logic       hs_last [64];
    int         cd;

    block_sequencer_if #(.COORD_W(8)) bus ();

    block_sequencer #(
        .COORD_W        (8),
        .TIMEOUT_CYCLES (16),
        .TMO_W          (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event monitor sampling pre-edge values
    initial begin
        n_start = 0;
        n_fetch = 0;
        n_fdone = 0;
        n_hs    = 0;
    end
    always @(posedge clk) begin
        if (bus.start_block) n_start++;
        if (bus.fetch_req)   n_fetch++;
        if (bus.frame_done)  n_fdone++;
        if (bus.out_valid && bus.out_ready && n_hs < 64) begin
            hs_row[n_hs]  = bus.out_row;
            hs_col[n_hs]  = bus.out_col;
            hs_last[n_hs] = bus.out_last;
            n_hs++;
        end
    end

    // Datapath model: block_done five cycles after start_block
    initial begin
        cd             = 0;
        bus.block_done = 1'b0;
    end
    always @(negedge clk) begin
        if (bus.start_block) begin
            cd             = 5;
            bus.block_done = 1'b0;
        end else if (cd > 0) begin
            cd--;
            bus.block_done = done_en && (cd == 0);
        end else begin
            bus.block_done = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [7:0] bx, input logic [7:0] by);
        bus.blocks_x    = bx;
        bus.blocks_y    = by;
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
    endtask

    task automatic wait_frame_done(input string tag);
        for (int i = 0; i < 400 && !bus.frame_done; i++) @(negedge clk);
        check(tag, 32'(bus.frame_done), 1);
    endtask

    task automatic wait_out_valid(input string tag);
        for (int i = 0; i < 100 && !bus.out_valid; i++) @(negedge clk);
        check(tag, 32'(bus.out_valid), 1);
    endtask

    int s_start, s_fetch, s_fdone, s_hs;

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        done_en         = 1'b1;
        rst_n           = 1'b0;
        bus.frame_start = 1'b0;
        bus.blocks_x    = '0;
        bus.blocks_y    = '0;
        bus.fetch_ack   = 1'b0;
        bus.out_ready   = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy",      32'(bus.busy), 0);
        check("rst_fetch_req", 32'(bus.fetch_req), 0);
        check("rst_start",     32'(bus.start_block), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_last",  32'(bus.out_last), 0);
        check("rst_fdone",     32'(bus.frame_done), 0);
        check("rst_err",       32'(bus.err), 0);
        check("rst_coords",    32'({bus.fetch_row, bus.fetch_col, bus.out_row, bus.out_col}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 2x2 frame, zero-wait handshakes
        bus.fetch_ack = 1'b1;
        bus.out_ready = 1'b1;
        s_start = n_start; s_hs = n_hs; s_fdone = n_fdone;
        start_frame(8'd2, 8'd2);
        check("f1_fetch_req", 32'(bus.fetch_req), 1);
        check("f1_busy",      32'(bus.busy), 1);
        wait_frame_done("f1_frame_done");
        check("f1_busy_at_done", 32'(bus.busy), 1);
        @(negedge clk);
        check("f1_busy_after",  32'(bus.busy), 0);
        check("f1_fdone_after", 32'(bus.frame_done), 0);
        check("f1_starts",      32'(n_start - s_start), 4);
        check("f1_hs",          32'(n_hs - s_hs), 4);
        check("f1_fdones",      32'(n_fdone - s_fdone), 1);
        check("f1_b0", 32'({hs_row[s_hs+0], hs_col[s_hs+0], 7'd0, hs_last[s_hs+0]}), 32'h0000_0000);
        check("f1_b1", 32'({hs_row[s_hs+1], hs_col[s_hs+1], 7'd0, hs_last[s_hs+1]}), 32'h0000_0100);
        check("f1_b2", 32'({hs_row[s_hs+2], hs_col[s_hs+2], 7'd0, hs_last[s_hs+2]}), 32'h0001_0000);
        check("f1_b3", 32'({hs_row[s_hs+3], hs_col[s_hs+3], 7'd0, hs_last[s_hs+3]}), 32'h0001_0101);

        // 3x1 frame with back-pressure on the second block
        bus.out_ready = 1'b0;
        s_hs = n_hs;
        start_frame(8'd3, 8'd1);
        wait_out_valid("f2_valid0");
        check("f2_col0", 32'(bus.out_col), 0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        wait_out_valid("f2_valid1");
        s_fetch = n_fetch;
        for (int k = 0; k < 4; k++) begin
            check("f2_hold_valid", 32'(bus.out_valid), 1);
            check("f2_hold_col",   32'(bus.out_col), 1);
            check("f2_hold_nofetch", 32'(bus.fetch_req), 0);
            @(negedge clk);
        end
        check("f2_no_fetch_cnt", 32'(n_fetch - s_fetch), 0);
        bus.out_ready = 1'b1;
        wait_frame_done("f2_frame_done");
        check("f2_hs", 32'(n_hs - s_hs), 3);
        check("f2_last", 32'({hs_col[s_hs+2], 7'd0, hs_last[s_hs+2]}), 32'h0201);
        check("f2_notlast", 32'(hs_last[s_hs+1]), 0);
        @(negedge clk);

        // Zero-dimension frame
        s_fetch = n_fetch;
        start_frame(8'd0, 8'd4);
        check("f3_fdone", 32'(bus.frame_done), 1);
        check("f3_busy",  32'(bus.busy), 0);
        @(negedge clk);
        check("f3_fdone_one", 32'(bus.frame_done), 0);
        check("f3_no_fetch",  32'(n_fetch - s_fetch), 0);

        // Watchdog: block_done never arrives
        done_en = 1'b0;
        s_fdone = n_fdone;
        start_frame(8'd1, 8'd1);
        for (int i = 0; i < 20 && !bus.start_block; i++) @(negedge clk);
        check("f4_start", 32'(bus.start_block), 1);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("f4_compute_busy", 32'({bus.busy, bus.err}), 32'b10);
        end
        @(negedge clk);
        check("f4_err",   32'(bus.err), 1);
        check("f4_idle",  32'(bus.busy), 0);
        repeat (3) @(negedge clk);
        check("f4_no_fdone", 32'(n_fdone - s_fdone), 0);
        done_en = 1'b1;
        start_frame(8'd1, 8'd1);
        check("f4_err_clear", 32'(bus.err), 0);
        wait_frame_done("f4_frame_done");
        @(negedge clk);

        // frame_start mid-frame is ignored
        s_hs = n_hs;
        start_frame(8'd2, 8'd1);
        repeat (3) @(negedge clk);
        start_frame(8'd7, 8'd3);
        bus.blocks_x = 8'd0;
        bus.blocks_y = 8'd0;
        wait_frame_done("f5_frame_done");
        check("f5_hs",   32'(n_hs - s_hs), 2);
        check("f5_last", 32'({hs_col[s_hs+1], 7'd0, hs_last[s_hs+1]}), 32'h0101);
        @(negedge clk);
        check("f5_idle", 32'(bus.busy), 0);

        // Reset during COMPUTE of block (0,1)
        start_frame(8'd2, 8'd2);
        for (int i = 0; i < 100 && !(bus.start_block && bus.fetch_col == 8'd1); i++) @(negedge clk);
        check("f6_reach", 32'({bus.start_block, bus.fetch_row, bus.fetch_col}), 32'h10001);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("f6_async_busy",  32'(bus.busy), 0);
        check("f6_async_coord", 32'({bus.fetch_col, bus.out_col, bus.out_valid, bus.start_block}), 0);
        s_start = n_start; s_fdone = n_fdone;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("f6_no_start", 32'(n_start - s_start), 0);
        check("f6_no_fdone", 32'(n_fdone - s_fdone), 0);
        start_frame(8'd2, 8'd2);
        check("f6_restart", 32'({bus.fetch_req, bus.fetch_row, bus.fetch_col}), 32'h10000);
        wait_frame_done("f6_frame_done");
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
